// File: rtl/spi_dda_pkg.sv
// Shared definitions for the SPI register-file slave: header layout, FSM states, address map.
package spi_dda_pkg;

    localparam int unsigned HDR_WR       = 7;
    localparam int unsigned HDR_STEP     = 6;
    localparam int unsigned HDR_ADDR_MSB = 5;
    localparam int unsigned HDR_ADDR_LSB = 0;

    localparam logic [5:0] STATE_BASE_DEFAULT = 6'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } spi_state_e;

endpackage

// File: rtl/spi_dda_regfile_sync.sv
// Two-flop synchroniser for an asynchronous pin, plus an edge-detect flop giving rise/fall strobes.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[1:0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {3{RST_VAL}};
        else     sync_q <= sync_d;
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_dda_regfile.sv
// SPI mode-0 slave: 8-bit header then auto-incrementing W-bit words into parameter
// registers (write) or out of parameters / snapshotted solver state (read), with step request.
module spi_dda_regfile
    import spi_dda_pkg::*;
#(
    parameter int unsigned          W          = 16,
    parameter int unsigned          NPARAM     = 4,
    parameter int unsigned          NSTATE     = 2,
    parameter logic [NPARAM*W-1:0]  PARAM_RST  = {NPARAM{16'h3000}},
    parameter logic [5:0]           STATE_BASE = STATE_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [NSTATE*W-1:0]   state_in,
    output logic [NPARAM*W-1:0]   param_out,
    output logic                  param_wr,
    output logic [4:0]            param_addr,
    output logic                  step
);

    spi_state_e state_q, state_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [W-2:0]        shift_q, shift_d;
    logic [W-1:0]        tx_q, tx_d;
    logic [5:0]          addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                step_req_q, step_req_d;
    logic [NSTATE*W-1:0] snap_q, snap_d;
    logic [NPARAM*W-1:0] param_q, param_d;
    logic                param_wr_q, param_wr_d;
    logic [4:0]          param_addr_q, param_addr_d;
    logic                step_q, step_d;
    logic                miso_q, miso_d;
    logic                miso_oe_q, miso_oe_d;
    logic [1:0]          ready_q, ready_d;
    logic                armed_q, armed_d;

    logic sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall, mosi_lvl;
    logic sclk_lvl_unused, mosi_rise_unused, mosi_fall_unused;
    logic [W-1:0] rx_word;
    logic [7:0]   hdr;
    logic [5:0]   rd_addr;
    logic [W-1:0] rd_word;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign rx_word = {shift_q, mosi_lvl};
    assign hdr     = rx_word[7:0];

    // Word to present next: header address when the header completes, else the following address.
    always_comb begin
        rd_addr = (state_q == ST_HDR) ? hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] : addr_q + 6'd1;
        rd_word = '0;
        for (int unsigned k = 0; k < NSTATE; k++)
            if ({1'b0, rd_addr} == 7'(STATE_BASE) + 7'(k)) rd_word = snap_q[k*W +: W];
        for (int unsigned k = 0; k < NPARAM; k++)
            if (rd_addr == 6'(k)) rd_word = param_q[k*W +: W];
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        step_req_d   = step_req_q;
        snap_d       = snap_q;
        param_d      = param_q;
        param_wr_d   = 1'b0;
        param_addr_d = param_addr_q;
        step_d       = 1'b0;
        miso_d       = miso_q;
        miso_oe_d    = ~cs_lvl;
        // A reset can land mid-frame with cs_n still low; only accept a frame start once
        // cs_n has been seen high through a flushed synchroniser.
        ready_d      = {ready_q[0], 1'b1};
        armed_d      = armed_q | (ready_q[1] & cs_lvl);

        if (cs_rise) begin
            step_d  = (state_q == ST_DATA) && step_req_q;
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall && armed_q) begin
                        state_d    = ST_HDR;
                        bit_cnt_d  = '0;
                        step_req_d = 1'b0;
                        snap_d     = state_in;
                    end
                end
                ST_HDR: begin
                    if (sclk_rise) begin
                        shift_d   = rx_word[W-2:0];
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            state_d    = ST_DATA;
                            bit_cnt_d  = '0;
                            addr_d     = hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
                            wr_d       = hdr[HDR_WR];
                            step_req_d = hdr[HDR_STEP];
                            tx_d       = rd_word;
                        end
                    end
                end
                ST_DATA: begin
                    if (wr_q) begin
                        if (sclk_rise) begin
                            shift_d   = rx_word[W-2:0];
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            if (bit_cnt_q == 6'(W-1)) begin
                                bit_cnt_d = '0;
                                addr_d    = addr_q + 6'd1;
                                for (int unsigned k = 0; k < NPARAM; k++) begin
                                    if (addr_q == 6'(k)) begin
                                        param_d[k*W +: W] = rx_word;
                                        param_wr_d        = 1'b1;
                                        param_addr_d      = 5'(k);
                                    end
                                end
                            end
                        end
                    end else if (sclk_fall) begin
                        miso_d    = tx_q[W-1];
                        tx_d      = {tx_q[W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'(W-1)) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + 6'd1;
                            tx_d      = rd_word;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            step_req_q   <= 1'b0;
            snap_q       <= '0;
            param_q      <= PARAM_RST;
            param_wr_q   <= 1'b0;
            param_addr_q <= '0;
            step_q       <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            ready_q      <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            step_req_q   <= step_req_d;
            snap_q       <= snap_d;
            param_q      <= param_d;
            param_wr_q   <= param_wr_d;
            param_addr_q <= param_addr_d;
            step_q       <= step_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            ready_q      <= ready_d;
            armed_q      <= armed_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign param_out  = param_q;
    assign param_wr   = param_wr_q;
    assign param_addr = param_addr_q;
    assign step       = step_q;

endmodule

// File: tb/tb_spi_dda_regfile.sv
// Self-checking bench for spi_dda_regfile: directed frames plus random frames against a register-map model.
module tb_spi_dda_regfile;

    localparam int unsigned W    = 16;
    localparam int unsigned NP   = 4;
    localparam int unsigned NS   = 2;
    localparam int unsigned HALF = 8;
    localparam logic [NP*W-1:0] PRST = {NP{16'h3000}};

    logic clk = 1'b0;
    logic rst, sclk, cs_n, mosi;
    logic miso, miso_oe, param_wr, step;
    logic [NS*W-1:0] state_in;
    logic [NP*W-1:0] param_out;
    logic [4:0]      param_addr;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, step_cnt = 0;
    int exp_wr = 0, exp_step = 0, quiet_err = 0;
    int unsigned addr_idx = 0;
    int got_addr[$];
    int exp_addr[$];
    logic [15:0] mdl_param [NP];
    logic [15:0] mdl_snap  [NS];
    logic [15:0] wbuf [0:8];
    logic [15:0] rbuf [0:8];
    logic [5:0]  pool [0:9] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h05,
                                6'h1F, 6'h20, 6'h21, 6'h22, 6'h3F};

    spi_dda_regfile #(
        .W(16), .NPARAM(4), .NSTATE(2), .PARAM_RST({4{16'h3000}}), .STATE_BASE(6'h20)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .state_in(state_in),
        .param_out(param_out), .param_wr(param_wr), .param_addr(param_addr), .step(step)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (param_wr) begin
            wr_cnt++;
            got_addr.push_back(int'(param_addr));
        end
        if (step) step_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mdl_read(input int unsigned a);
        if (a < NP) return mdl_param[a];
        if (a >= 32 && a < 32 + NS) return mdl_snap[a - 32];
        return 16'h0000;
    endfunction

    function automatic logic [NP*W-1:0] mdl_vec();
        logic [NP*W-1:0] v;
        for (int k = 0; k < NP; k++) v[k*W +: W] = mdl_param[k];
        return v;
    endfunction

    task automatic bit_x(input logic b, output logic rb);
        mosi = b;
        repeat (HALF) @(negedge clk);
        rb = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] hdr, input int unsigned hbits,
                             input int unsigned nwords, input int unsigned xbits);
        logic rb;
        logic [15:0] w;
        int unsigned a, nbits, wi, bp;
        for (int k = 0; k < NS; k++) mdl_snap[k] = state_in[k*W +: W];
        quiet_err = 0;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < int'(hbits); i++) begin
            bit_x(hdr[7-i], rb);
            if (rb !== 1'b0) quiet_err++;
        end
        if (hbits == 8) begin
            nbits = nwords * 16 + xbits;
            for (int unsigned n = 0; n < nbits; n++) begin
                wi = n / 16;
                bp = 15 - (n % 16);
                w = wbuf[wi];
                bit_x(w[bp], rb);
                if (hdr[7]) begin
                    if (rb !== 1'b0) quiet_err++;
                end else begin
                    w = rbuf[wi];
                    w[bp] = rb;
                    rbuf[wi] = w;
                end
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);

        a = int'(hdr[5:0]);
        if (hbits == 8) begin
            if (hdr[6]) exp_step++;
            for (int unsigned k = 0; k < nwords; k++) begin
                if (hdr[7]) begin
                    if (a < NP) begin
                        mdl_param[a] = wbuf[k];
                        exp_addr.push_back(int'(a));
                        exp_wr++;
                    end
                end else begin
                    chk($sformatf("rd_a%0h", a), 64'(rbuf[k]), 64'(mdl_read(a)));
                end
                a = (a + 1) % 64;
            end
        end
        chk("miso_quiet", 64'(quiet_err), 64'(0));
        chk("wr_cnt", 64'(wr_cnt), 64'(exp_wr));
        chk("step_cnt", 64'(step_cnt), 64'(exp_step));
        chk("param_out", 64'(param_out), 64'(mdl_vec()));
        while (addr_idx < exp_addr.size()) begin
            chk("wr_addr", 64'((addr_idx < got_addr.size()) ? got_addr[addr_idx] : -1),
                64'(exp_addr[addr_idx]));
            addr_idx++;
        end
    endtask

    initial begin
        logic rb;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        state_in = {16'h1234, 16'hABCD};
        for (int k = 0; k < NP; k++) mdl_param[k] = 16'h3000;
        for (int k = 0; k < 9; k++) begin wbuf[k] = '0; rbuf[k] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_param_out", 64'(param_out), 64'(PRST));
        chk("rst_miso", 64'(miso), 64'(0));
        chk("rst_miso_oe", 64'(miso_oe), 64'(0));
        chk("rst_param_wr", 64'(param_wr), 64'(0));
        chk("rst_param_addr", 64'(param_addr), 64'(0));
        chk("rst_step", 64'(step), 64'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Read four parameters at reset value.
        run_frame(8'h00, 8, 4, 0);
        chk("t1_word3", 64'(rbuf[3]), 64'(16'h3000));

        // Two-word write from address 1.
        wbuf[0] = 16'h4000; wbuf[1] = 16'h5000;
        run_frame(8'h81, 8, 2, 0);
        chk("t2_reg1", 64'(param_out[31:16]), 64'(16'h4000));
        chk("t2_reg2", 64'(param_out[47:32]), 64'(16'h5000));

        // Step request with full header, then one aborted inside the header.
        run_frame(8'h40, 8, 0, 0);
        run_frame(8'h40, 5, 0, 0);

        // State snapshot held while state_in moves mid-frame.
        state_in = {16'h1234, 16'hABCD};
        fork
            run_frame(8'h20, 8, 2, 0);
            begin
                repeat (60) @(negedge clk);
                state_in = 32'h5555_6666;
            end
        join
        chk("t4_ch0", 64'(rbuf[0]), 64'(16'hABCD));
        chk("t4_ch1", 64'(rbuf[1]), 64'(16'h1234));

        // Full word then a partial word; then a write to an unmapped address.
        wbuf[0] = 16'h7777; wbuf[1] = 16'hFFFF;
        run_frame(8'h83, 8, 1, 7);
        chk("t5_reg3", 64'(param_out[63:48]), 64'(16'h7777));
        wbuf[0] = 16'hBEEF;
        run_frame(8'h90, 8, 1, 0);

        // Reset in the middle of a write data word.
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 7; i >= 0; i--) bit_x((i == 7), rb);
        for (int i = 0; i < 6; i++) bit_x(1'b1, rb);
        rst = 1'b1;
        #1;
        chk("t6_rst_param", 64'(param_out), 64'(PRST));
        chk("t6_rst_oe", 64'(miso_oe), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NP; k++) mdl_param[k] = 16'h3000;
        for (int i = 0; i < 26; i++) bit_x(1'b1, rb);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        chk("t6_no_wr", 64'(wr_cnt), 64'(exp_wr));
        chk("t6_params", 64'(param_out), 64'(mdl_vec()));
        wbuf[0] = 16'h1111;
        run_frame(8'h80, 8, 1, 0);

        // Random frames.
        for (int n = 0; n < 14; n++) begin
            logic [7:0] h;
            int unsigned hb, nw, xb;
            h[7]   = 1'($urandom_range(0, 1));
            h[6]   = ($urandom_range(0, 3) == 0);
            h[5:0] = pool[$urandom_range(0, 9)];
            hb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8;
            nw = $urandom_range(0, 3);
            xb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            for (int k = 0; k < 9; k++) wbuf[k] = 16'($urandom);
            state_in = $urandom;
            run_frame(h, hb, nw, xb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_dda_regfile.md
Name: spi_dda_regfile

Overview:
Parametrised SPI mode-0 slave giving an external host addressed access to the solver. It exposes NPARAM writable parameter registers (mu, initial conditions, ...) and NSTATE read-only state channels. Each frame carries an 8-bit header (R/W, step request, address) followed by auto-incrementing W-bit data words. It sits between the chip pins and the dda core and generalises the fixed 32-bit single-register exchange with a host-controlled step pulse.

Parameters:
W, 16, data word width in bits (posit word size), 8..32
NPARAM, 4, number of R/W parameter registers, 1..32
NSTATE, 2, number of read-only state channels, 1..32
PARAM_RST, {NPARAM{16'h3000}}, flattened reset value of the parameter registers, NPARAM*W bits
STATE_BASE, 6'h20, header address of state channel 0

Ports:
clk  in  1  system clock; must run at 8x sclk or faster
rst  in  1  asynchronous reset, active-high
sclk  in  1  SPI clock, asynchronous to clk
cs_n  in  1  SPI chip select, active low, asynchronous
mosi  in  1  SPI data in
miso  out  1  SPI data out, MSB first
miso_oe  out  1  high while the synchronised cs_n is low
state_in  in  NSTATE*W  solver state, channel k at bits [k*W +: W]
param_out  out  NPARAM*W  parameter registers, register k at bits [k*W +: W]
param_wr  out  1  one-clk pulse when any parameter register is written
param_addr  out  5  index of the register written, valid with param_wr
step  out  1  one-clk pulse requesting one solver iteration

Behaviour:
- Single clock is clk. Reset is asynchronous and active-high (rst). The clock and reset are named clk and rst.
- Reset values: param_out=PARAM_RST; miso=0; miso_oe=0; param_wr=0; param_addr=0; step=0. Synchroniser stages reset to idle (cs_n=1, sclk=0), so the FSM is in IDLE.
- Input synchronisation: each of sclk, cs_n and mosi passes through 2 flops plus 1 edge-detect flop. Edge events are sclk rise, sclk fall, cs fall and cs rise.
- FSM states: IDLE, HDR, DATA.
  - IDLE -> HDR on cs fall. On that cycle the bit counter is cleared and all NSTATE state_in words are snapshotted for a coherent read.
  - HDR shifts mosi in on each sclk rise. After the 8th bit it latches the header and enters DATA.
  - Header format: bit7 = write(1)/read(0); bit6 = step request; bits5:0 = start address.
  - Any state -> IDLE on cs rise. This has priority over a simultaneous sclk edge.
- Write frame: mosi is shifted in on sclk rise. When W bits are complete, the word commits on the next clk:
  - If address < NPARAM: update that register and pulse param_wr with param_addr=address.
  - Any other address: the write is ignored silently and there is no pulse.
  - The address then increments by 1, wrapping modulo 64.
- Read frame: the read word is loaded on the cycle the header completes.
  - Address < NPARAM returns the parameter value.
  - STATE_BASE <= address < STATE_BASE+NSTATE returns the snapshotted state.
  - Any other address returns 0.
  - The word shifts out MSB first, one bit per sclk fall. The MSB appears on the sclk fall following the 8th header rise.
  - After W bits the address increments and the next word loads. Frames may read any number of words.
  - During HDR and write frames miso=0.
- Step: pulse step for exactly 1 clk, on the cycle cs rise is detected, only if the full header was received with bit6=1.
  - A frame aborted inside the header never steps.
  - A frame may both write parameters and request a step. The writes are committed before step is pulsed.
- Partial word at cs rise: the word is discarded with no write and no address side effect.
- rst asserted mid-frame: all outputs return to reset values. Remaining bits of that frame are ignored until a fresh cs fall.
- No combinational path from any input to any output.

Decomposition:
- Package spi_dda_pkg holds:
  - header bit positions (HDR_WR=7, HDR_STEP=6, HDR_ADDR 5:0)
  - the FSM state enum
  - the STATE_BASE default
- Natural sub-module: spi_sync_edge. It is a 2-flop synchroniser with edge-detect flop and rise/fall outputs, instantiated three times for sclk, cs_n and mosi (mosi uses only the level output).
- Shift, address and FSM logic stays in the top module.

Test Plan:
- Reset then read header 0x00, 4 words -> miso returns 0x3000, 0x3000, 0x3000, 0x3000; param_wr never asserted.
- Write header 0x81 with data 0x4000, 0x5000 -> param_wr pulses twice (addr 1 then 2); param_out reg1=0x4000, reg2=0x5000; step stays 0.
- Header 0x40 (read+step, addr 0), cs raised after header -> exactly one step pulse on cs-rise cycle; a second frame with header aborted after 5 bits -> no step.
- state_in = {0x1234, 0xABCD}; read header 0x20, 2 words; state_in changes mid-frame -> miso returns 0xABCD then 0x1234 (snapshot held).
- Write header 0x83, one full word 0x7777 then 7 bits and cs rise -> reg3=0x7777, no further param_wr; write to addr 0x10 -> ignored.
- Assert rst mid write-data word -> param_out=PARAM_RST immediately; remaining sclk edges cause no writes until next cs fall.
